shader_swizzle: RTL and testbench

SHADER_SWIZZLE -- requirements
Module: shader_swizzle

---
 rtl/shader_swizzle_pkg.sv | 19 +
 rtl/shader_swizzle_lane.sv | 43 ++++
 rtl/shader_swizzle.sv | 105 ++++++++++
 tb/tb_shader_swizzle.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shader_swizzle_pkg.sv
// Shared types for the shader swizzle unit: lane and lane-index types at the
// default geometry, plus the result-buffer occupancy encoding.
package shader_pkg;

  localparam int SHADER_CHANNELS = 4;
  localparam int SHADER_WIDTH    = 4;
  localparam int SHADER_IDX_W    = $clog2(SHADER_CHANNELS);

  typedef logic [SHADER_WIDTH-1:0] lane_t;
  typedef logic [SHADER_IDX_W-1:0] lane_idx_t;

  // Occupancy of the 2-entry in-order result buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/shader_swizzle_lane.sv
// One output lane of the swizzle: pick a source lane by index, optionally
// negate it, and fall back to the prior destination lane when masked.
// Optional feature macro: SHADER_SWIZZLE_NEGATE_EN (adds the negate path).
module shader_swizzle_lane
  import shader_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  localparam int IDX_W   = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] src,
  input  logic [WIDTH-1:0]          dst,
  input  logic [IDX_W-1:0]          sel,
  input  logic                      wmask,
`ifdef SHADER_SWIZZLE_NEGATE_EN
  input  logic                      neg,
`endif
  output logic [WIDTH-1:0]          res
);

  logic [WIDTH-1:0] picked;
  logic [WIDTH-1:0] written;

  assign picked = src[int'(sel)*WIDTH +: WIDTH];

`ifdef SHADER_SWIZZLE_NEGATE_EN
  // Two's-complement negate wraps modulo 2^WIDTH; only the written path sees it.
  always_comb begin
    written = neg ? (~picked + {{(WIDTH-1){1'b0}}, 1'b1}) : picked;
  end
`else
  // Without the negate feature the selected lane is written unchanged.
  always_comb begin
    written = picked;
  end
`endif

  // Masked lanes keep the prior destination value untouched.
  always_comb begin
    res = wmask ? written : dst;
  end

endmodule

// File: rtl/shader_swizzle.sv
// Shader swizzle unit: per-lane source select / write mask (and optional
// negate), with results captured at acceptance into a 2-entry in-order buffer.
// m_data comes straight from the head register; s_ready is registered.
// Optional feature macro: SHADER_SWIZZLE_NEGATE_EN (honours s_neg).
module shader_swizzle
  import shader_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [CHANNELS*WIDTH-1:0]           s_src,
  input  logic [CHANNELS*WIDTH-1:0]           s_dst,
  input  logic [CHANNELS*$clog2(CHANNELS)-1:0] s_map,
  input  logic [CHANNELS-1:0]                 s_wmask,
  input  logic [CHANNELS-1:0]                 s_neg,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [CHANNELS*WIDTH-1:0]           m_data
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam int DW    = CHANNELS * WIDTH;

  logic [DW-1:0] result;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic          ready_q;
  buf_state_e    state_q;
  buf_state_e    state_d;
  logic          accept;
  logic          pop;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    shader_swizzle_lane #(
      .CHANNELS (CHANNELS),
      .WIDTH    (WIDTH)
    ) u_lane (
      .src   (s_src),
      .dst   (s_dst[i*WIDTH +: WIDTH]),
      .sel   (s_map[i*IDX_W +: IDX_W]),
      .wmask (s_wmask[i]),
`ifdef SHADER_SWIZZLE_NEGATE_EN
      .neg   (s_neg[i]),
`endif
      .res   (result[i*WIDTH +: WIDTH])
    );
  end

`ifndef SHADER_SWIZZLE_NEGATE_EN
  // s_neg has no effect in this build; fold it into a deliberately dead net.
  logic unused_neg;
  assign unused_neg = ^s_neg;
`endif

  assign accept  = s_valid & ready_q;
  assign pop     = m_valid & m_ready;
  assign s_ready = ready_q;
  assign m_valid = (state_q != EMPTY);
  assign m_data  = head_q;

  // Next occupancy: accept-only grows, pop-only shrinks, both together hold.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = FULL;
        else if (!accept && pop) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Buffer registers: head feeds m_data, tail holds the second result.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= EMPTY;
      ready_q <= 1'b0;
      // NOTE: head must clear because it drives m_data directly; tail is cleared
      // too so a discarded entry can never resurface after reset.
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      case (state_q)
        EMPTY: if (accept) head_q <= result;
        ONE: begin
          if (accept && pop) head_q <= result;
          else if (accept)   tail_q <= result;
        end
        FULL:  if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shader_swizzle.sv
// Self-checking bench for shader_swizzle (default geometry 4 lanes x 4 bits).
// A queue-based reference model predicts occupancy, s_ready and result order;
// directed sections pin literal values, then a random phase stresses handshakes.
module tb_shader_swizzle;

  localparam int CH = 4;
  localparam int W  = 4;
  localparam int DW = CH * W;
  localparam int MW = CH * 2;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_src;
  logic [DW-1:0] s_dst;
  logic [MW-1:0] s_map;
  logic [CH-1:0] s_wmask;
  logic [CH-1:0] s_neg;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  bit started = 0;

  logic [DW-1:0] q[$];
  bit            rdy_e = 0;

  always #5 aclk = ~aclk;

  shader_swizzle dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_src   (s_src),
    .s_dst   (s_dst),
    .s_map   (s_map),
    .s_wmask (s_wmask),
    .s_neg   (s_neg),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference swizzle computed lane by lane from the functional rules.
  function automatic logic [DW-1:0] swz(input logic [DW-1:0] src, input logic [DW-1:0] dst,
                                        input logic [MW-1:0] map, input logic [CH-1:0] wm,
                                        input logic [CH-1:0] ng);
    logic [DW-1:0] r;
    for (int i = 0; i < CH; i++) begin
      int sel;
      int v;
      sel = int'(map[i*2 +: 2]);
      v   = int'(src[sel*W +: W]);
`ifdef SHADER_SWIZZLE_NEGATE_EN
      if (ng[i]) v = (16 - v) % 16;
`endif
      r[i*W +: W] = wm[i] ? W'(v) : dst[i*W +: W];
    end
    return r;
  endfunction

  // Behavioural model: a queue of pending results capped at two entries.
  always @(posedge aclk) begin
    bit acc;
    bit pp;
    if (!aresetn) begin
      q.delete();
      rdy_e = 0;
    end else begin
      acc = s_valid && rdy_e;
      pp  = (q.size() > 0) && m_ready;
      if (pp) begin
        void'(q.pop_front());
        pops++;
      end
      if (acc) q.push_back(swz(s_src, s_dst, s_map, s_wmask, s_neg));
      rdy_e = (q.size() < 2);
    end
    started = 1;
  end

  // Cycle-by-cycle comparison against the model, shortly after each edge.
  always @(posedge aclk) begin
    #2;
    if (started) begin
      check("m_valid", m_valid, q.size() > 0);
      check("s_ready", s_ready, rdy_e);
      if (q.size() > 0) check("m_data", m_data, q[0]);
    end
  end

  task automatic send(input logic [DW-1:0] src, input logic [DW-1:0] dst, input logic [MW-1:0] map,
                      input logic [CH-1:0] wm, input logic [CH-1:0] ng, output int waits);
    s_src = src; s_dst = dst; s_map = map; s_wmask = wm; s_neg = ng;
    s_valid = 1'b1;
    waits = 0;
    while (!s_ready && waits < 20) begin
      @(negedge aclk);
      waits++;
    end
    if (waits >= 20) begin
      check("send_timeout", 1, 0);
      s_valid = 1'b0;
      return;
    end
    @(posedge aclk);
    @(negedge aclk);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    repeat (4) @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int p0;
    int stalls;
    logic [DW-1:0] a_val;
    logic [DW-1:0] ng_exp;

    aresetn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s_src = '0; s_dst = '0; s_map = '0; s_wmask = '0; s_neg = '0;

    // Pin the reference model itself with hand-computed values.
    check("model_identity",  swz(16'h4321, 16'h0000, 8'hE4, 4'hF, 4'h0), 16'h4321);
    check("model_broadcast", swz(16'h4321, 16'hAAAA, 8'h00, 4'b0101, 4'h0), 16'hA1A1);
    check("model_reverse",   swz(16'h4321, 16'h0000, 8'h1B, 4'hF, 4'h0), 16'h1234);

    // Reset state.
    repeat (3) @(negedge aclk);
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_data",  m_data, 0);
    aresetn = 1'b1;
    check("rst_ready_before_edge", s_ready, 0);
    @(posedge aclk); #2;
    check("rst_ready_rises", s_ready, 1);
    @(negedge aclk);

    // Identity swizzle, visible one cycle after acceptance.
    m_ready = 1'b1;
    send(16'h4321, 16'h0000, 8'hE4, 4'hF, 4'h0, w);
    check("ident_valid", m_valid, 1);
    check("ident_data",  m_data, 16'h4321);
    @(negedge aclk);

    // Broadcast lane 0 with alternate lanes masked.
    send(16'h4321, 16'hAAAA, 8'h00, 4'b0101, 4'h0, w);
    check("bcast_data", m_data, 16'hA1A1);
    @(negedge aclk);

    // Negate request on lane 0.
`ifdef SHADER_SWIZZLE_NEGATE_EN
    ng_exp = 16'h000D;
`else
    ng_exp = 16'h0003;
`endif
    send(16'h0003, 16'h0000, 8'h00, 4'b0001, 4'b0001, w);
    check("neg_lane0", m_data[3:0], ng_exp[3:0]);
    drain();

    // Backpressure: two accepted, third held until downstream drains.
    m_ready = 1'b0;
    a_val = 16'h1357;
    send(a_val, 16'h0, 8'hE4, 4'hF, 4'h0, w);
    send(16'h2468, 16'h0, 8'hE4, 4'hF, 4'h0, w);
    check("bp_second_no_wait", w, 0);
    check("bp_ready_low", s_ready, 0);
    check("bp_head", m_data, a_val);
    s_src = 16'h9ABC; s_valid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("bp_stable_data",  m_data, a_val);
      check("bp_stable_valid", m_valid, 1);
      check("bp_still_full",   s_ready, 0);
    end
    m_ready = 1'b1;
    send(16'h9ABC, 16'h0, 8'hE4, 4'hF, 4'h0, w);
    check("bp_third_waited", w > 0, 1);
    drain();

    // Throughput: 16 back-to-back requests with downstream always ready.
    p0 = pops;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      send(DW'($urandom), DW'($urandom), MW'($urandom), CH'($urandom), CH'($urandom), w);
      stalls += w;
    end
    @(posedge aclk); @(negedge aclk);
    check("tput_no_stalls", stalls, 0);
    check("tput_results", pops - p0, 16);
    drain();

    // Random handshakes and data.
    for (int i = 0; i < 500; i++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      s_src = DW'($urandom); s_dst = DW'($urandom); s_map = MW'($urandom);
      s_wmask = CH'($urandom); s_neg = CH'($urandom);
      @(negedge aclk);
    end
    s_valid = 1'b0;
    drain();

    // Reset while FULL discards both entries.
    m_ready = 1'b0;
    send(16'h1111, 16'h0, 8'hE4, 4'hF, 4'h0, w);
    send(16'h2222, 16'h0, 8'hE4, 4'hF, 4'h0, w);
    check("rstfull_full", s_ready, 0);
    aresetn = 1'b0;
    @(posedge aclk); #2;
    check("rstfull_m_valid", m_valid, 0);
    check("rstfull_m_data",  m_data, 0);
    check("rstfull_s_ready", s_ready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_ready = 1'b1;
    @(posedge aclk); #2;
    check("rstfull_ready_back", s_ready, 1);
    check("rstfull_no_output",  m_valid, 0);
    repeat (3) @(negedge aclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
